bubram_loader: RTL and testbench

BUBRAM_LOADER -- requirements
Module: bubram_loader

---
 rtl/bubram_loader_pkg.sv | 23 ++
 rtl/bubram_loader_if.sv | 38 +++
 rtl/bubram_loader_addr_ctr.sv | 52 +++++
 rtl/bubram_loader.sv | 172 +++++++++++++++++
 tb/tb_bubram_loader.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/bubram_loader_pkg.sv
// Shared mode encodings, FSM states and default widths for the boot RAM loader.
// No logic, no latency, no backpressure.
package bubram_loader_pkg;

  localparam int AW_DEF   = 12;
  localparam int LENW_DEF = 13;

  typedef enum logic [1:0] {
    MODE_LOAD   = 2'b00,
    MODE_FILL   = 2'b01,
    MODE_VERIFY = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_VREQ,
    ST_VCMP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/bubram_loader_if.sv
// Command, byte-stream and RAM port bundle of the loader; no latency of its own.
// master drives commands, stream and RAM read data; slave is the loader itself.
interface bubram_loader_if #(
  parameter int AW   = bubram_loader_pkg::AW_DEF,
  parameter int LENW = bubram_loader_pkg::LENW_DEF
);

  logic            i_START;
  logic [1:0]      i_MODE;
  logic [AW-1:0]   i_BASE;
  logic [LENW-1:0] i_LEN;
  logic [7:0]      i_FILL;
  logic [7:0]      i_SDATA;
  logic            i_SVALID;
  logic            o_SREADY;
  logic [AW-1:0]   o_RAM_ADDR;
  logic [7:0]      o_RAM_DIN;
  logic            o_RAM_WR_n;
  logic            o_RAM_RD_n;
  logic [7:0]      i_RAM_DOUT;
  logic            o_BUSY;
  logic            o_DONE;
  logic            o_ERR;
  logic [AW-1:0]   o_ERR_ADDR;

  modport master (
    output i_START, i_MODE, i_BASE, i_LEN, i_FILL, i_SDATA, i_SVALID, i_RAM_DOUT,
    input  o_SREADY, o_RAM_ADDR, o_RAM_DIN, o_RAM_WR_n, o_RAM_RD_n,
           o_BUSY, o_DONE, o_ERR, o_ERR_ADDR
  );

  modport slave (
    input  i_START, i_MODE, i_BASE, i_LEN, i_FILL, i_SDATA, i_SVALID, i_RAM_DOUT,
    output o_SREADY, o_RAM_ADDR, o_RAM_DIN, o_RAM_WR_n, o_RAM_RD_n,
           o_BUSY, o_DONE, o_ERR, o_ERR_ADDR
  );

endinterface

// File: rtl/bubram_loader_addr_ctr.sv
// RAM address / remaining-byte counter: load BASE+LEN, step by one, wrap modulo 2^AW.
// Updates one edge after load/step; no backpressure, stepping stops at zero.
module bubram_addr_ctr
  import bubram_loader_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int LENW = LENW_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [AW-1:0]   base_i,
  input  logic [LENW-1:0] len_i,
  input  logic            step_i,
  output logic [AW-1:0]   addr_o,
  output logic            last_o,
  output logic            zero_o
);

  // A transfer can never exceed the whole RAM.
  localparam logic [LENW-1:0] MAX_LEN = LENW'(1) << AW;

  logic [AW-1:0]   addr_q, addr_d;
  logic [LENW-1:0] rem_q, rem_d;

  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (load_i) begin
      addr_d = base_i;
      rem_d  = (len_i > MAX_LEN) ? MAX_LEN : len_i;
    end else if (step_i && (rem_q != '0)) begin
      addr_d = addr_q + AW'(1);
      rem_d  = rem_q - LENW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (rem_q == LENW'(1));
  assign zero_o = (rem_q == '0);

endmodule

// File: rtl/bubram_loader.sv
// Boot RAM loader: LOAD stream->RAM, FILL constant, VERIFY RAM against stream; registered RAM strobes.
// Write lands one cycle after the stream transfer; o_SREADY throttles the stream (1 B/cycle write, 1 B/2 cycles verify).
module bubram_loader
  import bubram_loader_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int LENW = LENW_DEF
) (
  input  logic           i_EMU_MCLK,
  input  logic           i_EMU_RST,
  bubram_loader_if.slave bus
);

  state_e        state_q;
  mode_e         mode_q;
  logic [7:0]    fill_q;
  logic [7:0]    byte_q;
  logic          sready_q;
  logic          busy_q;
  logic          done_q;
  logic          wr_n_q;
  logic          rd_n_q;
  logic          err_q;
  logic [AW-1:0] err_addr_q;
  logic [AW-1:0] ram_addr_q;
  logic [7:0]    ram_din_q;

  logic          xfer;
  logic          ctr_load;
  logic          ctr_step;
  logic [AW-1:0] ctr_addr;
  logic          ctr_last;
  logic          ctr_zero;

  assign xfer     = bus.i_SVALID && sready_q;
  assign ctr_load = (state_q == ST_IDLE) && bus.i_START;
  assign ctr_step = ((state_q == ST_WRITE) && !ctr_zero && ((mode_q == MODE_FILL) || xfer))
                 || ((state_q == ST_VREQ) && xfer);

  bubram_addr_ctr #(
    .AW   (AW),
    .LENW (LENW)
  ) u_ctr (
    .clk_i  (i_EMU_MCLK),
    .rst_i  (i_EMU_RST),
    .load_i (ctr_load),
    .base_i (bus.i_BASE),
    .len_i  (bus.i_LEN),
    .step_i (ctr_step),
    .addr_o (ctr_addr),
    .last_o (ctr_last),
    .zero_o (ctr_zero)
  );

  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_RST) begin
    if (i_EMU_RST) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_LOAD;
      fill_q     <= '0;
      byte_q     <= '0;
      sready_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wr_n_q <= 1'b1;
          rd_n_q <= 1'b1;
          done_q <= 1'b0;
          if (bus.i_START) begin
            mode_q     <= mode_e'(bus.i_MODE);
            fill_q     <= bus.i_FILL;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            if ((bus.i_LEN == '0) || (mode_e'(bus.i_MODE) == MODE_RSVD)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else if (mode_e'(bus.i_MODE) == MODE_VERIFY) begin
              state_q  <= ST_VREQ;
              busy_q   <= 1'b1;
              sready_q <= 1'b1;
            end else begin
              state_q  <= ST_WRITE;
              busy_q   <= 1'b1;
              sready_q <= (mode_e'(bus.i_MODE) == MODE_LOAD);
            end
          end
        end

        // Count reaching zero means the final write is on the bus this cycle.
        ST_WRITE: begin
          if (ctr_zero) begin
            state_q  <= ST_DONE;
            wr_n_q   <= 1'b1;
            sready_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else if (mode_q == MODE_FILL) begin
            wr_n_q     <= 1'b0;
            ram_addr_q <= ctr_addr;
            ram_din_q  <= fill_q;
          end else if (xfer) begin
            wr_n_q     <= 1'b0;
            ram_addr_q <= ctr_addr;
            ram_din_q  <= bus.i_SDATA;
            sready_q   <= !ctr_last;
          end else begin
            wr_n_q <= 1'b1;
          end
        end

        ST_VREQ: begin
          if (xfer) begin
            byte_q     <= bus.i_SDATA;
            ram_addr_q <= ctr_addr;
            rd_n_q     <= 1'b0;
            sready_q   <= 1'b0;
            state_q    <= ST_VCMP;
          end
        end

        // RAM data from the falling-edge read is valid at this edge.
        ST_VCMP: begin
          rd_n_q <= 1'b1;
          if ((bus.i_RAM_DOUT != byte_q) && !err_q) begin
            err_q      <= 1'b1;
            err_addr_q <= ram_addr_q;
          end
          if (ctr_zero) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q  <= ST_VREQ;
            sready_q <= 1'b1;
          end
        end

        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q  <= ST_IDLE;
          wr_n_q   <= 1'b1;
          rd_n_q   <= 1'b1;
          sready_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_SREADY   = sready_q;
  assign bus.o_RAM_ADDR = ram_addr_q;
  assign bus.o_RAM_DIN  = ram_din_q;
  assign bus.o_RAM_WR_n = wr_n_q;
  assign bus.o_RAM_RD_n = rd_n_q;
  assign bus.o_BUSY     = busy_q;
  assign bus.o_DONE     = done_q;
  assign bus.o_ERR      = err_q;
  assign bus.o_ERR_ADDR = err_addr_q;

endmodule

// File: tb/tb_bubram_loader.sv
// Directed bench for bubram_loader: table of commands with hand-computed results plus
// hand sequences for START-while-DONE and reset mid-FILL; a falling-edge RAM model answers reads.
module tb_bubram_loader;
  import bubram_loader_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bubram_loader_if #(.AW(12), .LENW(13)) bus ();

  bubram_loader #(.AW(12), .LENW(13)) dut (
    .i_EMU_MCLK (clk),
    .i_EMU_RST  (rst),
    .bus        (bus)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [11:0] base;
    logic [12:0] len;
    logic [7:0]  fill;
    logic [31:0] sbytes;
    logic [15:0] vpat;
    bit          spur;
    int          e_cyc;
    logic [15:0] e_wpat;
    logic [15:0] e_rpat;
    int          e_wr;
    int          e_rd;
    int          e_srdy;
    logic [31:0] e_first;
    logic [31:0] e_last;
    logic [31:0] e_ldat;
    logic        e_err;
    logic [11:0] e_eaddr;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // RAM model and bus monitor, all on the falling edge.
  logic [7:0]  mem [0:4095];
  logic [11:0] stb_log [0:8191];
  int          stb_n = 0;
  int          wr_cnt = 0, rd_cnt = 0, srdy_cnt = 0, done_cnt = 0, overlap = 0;
  logic [7:0]  last_wd = 8'h00;
  logic        srdy_neg = 1'b0;

  always @(negedge clk) begin
    srdy_neg = bus.o_SREADY;
    if (bus.o_SREADY) srdy_cnt++;
    if (bus.o_DONE) done_cnt++;
    if (!bus.o_RAM_WR_n && !bus.o_RAM_RD_n) overlap++;
    if (!bus.o_RAM_WR_n) begin
      mem[bus.o_RAM_ADDR] = bus.o_RAM_DIN;
      last_wd = bus.o_RAM_DIN;
      wr_cnt++;
    end
    if (!bus.o_RAM_RD_n) begin
      bus.i_RAM_DOUT = mem[bus.o_RAM_ADDR];
      rd_cnt++;
    end
    if (!bus.o_RAM_WR_n || !bus.o_RAM_RD_n) begin
      stb_log[stb_n & 8191] = bus.o_RAM_ADDR;
      stb_n++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] mode, input logic [11:0] base, input logic [12:0] len,
                              input logic [7:0] fill, input logic [31:0] sbytes, input logic [15:0] vpat,
                              input bit spur, input int e_cyc, input logic [15:0] e_wpat,
                              input logic [15:0] e_rpat, input int e_wr, input int e_rd, input int e_srdy,
                              input logic [31:0] e_first, input logic [31:0] e_last,
                              input logic [31:0] e_ldat, input logic e_err, input logic [11:0] e_eaddr);
    vec_t v;
    v.mode = mode; v.base = base; v.len = len; v.fill = fill; v.sbytes = sbytes; v.vpat = vpat;
    v.spur = spur; v.e_cyc = e_cyc; v.e_wpat = e_wpat; v.e_rpat = e_rpat; v.e_wr = e_wr;
    v.e_rd = e_rd; v.e_srdy = e_srdy; v.e_first = e_first; v.e_last = e_last; v.e_ldat = e_ldat;
    v.e_err = e_err; v.e_eaddr = e_eaddr;
    return v;
  endfunction

  task automatic do_vec(input vec_t v, input string nm);
    int cyc, idx, w0, r0, s0, d0, n0;
    logic [15:0] wp, rp;
    logic [31:0] fa, la, ld;
    bit fin;
    w0 = wr_cnt; r0 = rd_cnt; s0 = srdy_cnt; d0 = done_cnt; n0 = stb_n;
    wp = '0; rp = '0;
    bus.i_START = 1'b1; bus.i_MODE = v.mode; bus.i_BASE = v.base;
    bus.i_LEN = v.len; bus.i_FILL = v.fill; bus.i_SVALID = 1'b0;
    @(posedge clk); #2;
    bus.i_START = 1'b0;
    cyc = 0; idx = 0; fin = bus.o_DONE;
    while (!fin && cyc < 5000) begin
      bus.i_SVALID = (cyc < 16) ? v.vpat[cyc] : 1'b1;
      bus.i_SDATA  = (idx < 4) ? v.sbytes[8*idx +: 8] : 8'hEE;
      bus.i_START  = v.spur && (cyc == 2);
      if (v.spur && cyc == 2) begin
        bus.i_MODE = 2'b01; bus.i_BASE = 12'h500; bus.i_LEN = 13'd7;
      end
      @(posedge clk); #2;
      if (bus.i_SVALID && srdy_neg) idx++;
      cyc++;
      if (cyc <= 16) begin
        wp[cyc-1] = !bus.o_RAM_WR_n;
        rp[cyc-1] = !bus.o_RAM_RD_n;
      end
      fin = bus.o_DONE;
    end
    bus.i_START = 1'b0; bus.i_SVALID = 1'b0;
    if (!fin) cyc = -1;
    repeat (2) begin @(posedge clk); #2; end
    fa = (stb_n != n0) ? 32'(stb_log[n0 & 8191]) : 32'hFFFF_FFFF;
    la = (stb_n != n0) ? 32'(stb_log[(stb_n - 1) & 8191]) : 32'hFFFF_FFFF;
    ld = (wr_cnt != w0) ? 32'(last_wd) : 32'hFFFF_FFFF;
    chk({nm, "_cycles"}, 32'(cyc), 32'(v.e_cyc));
    chk({nm, "_wrpat"}, 32'(wp), 32'(v.e_wpat));
    chk({nm, "_rdpat"}, 32'(rp), 32'(v.e_rpat));
    chk({nm, "_wrcnt"}, 32'(wr_cnt - w0), 32'(v.e_wr));
    chk({nm, "_rdcnt"}, 32'(rd_cnt - r0), 32'(v.e_rd));
    chk({nm, "_srdy"}, 32'(srdy_cnt - s0), 32'(v.e_srdy));
    chk({nm, "_first"}, fa, v.e_first);
    chk({nm, "_last"}, la, v.e_last);
    chk({nm, "_ldat"}, ld, v.e_ldat);
    chk({nm, "_err"}, 32'(bus.o_ERR), 32'(v.e_err));
    chk({nm, "_eaddr"}, 32'(bus.o_ERR_ADDR), 32'(v.e_eaddr));
    chk({nm, "_done"}, 32'(done_cnt - d0), 32'd1);
    chk({nm, "_busy"}, 32'(bus.o_BUSY), 32'd0);
  endtask

  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  initial begin
    vec_t vt [0:8];
    vec_t v0;
    int w0, d0;

    vt[0] = mk(2'b00, 12'h100, 13'd4, 8'h00, 32'h44332211, 16'hFFFF, 0,
               5, 16'h000F, 16'h0000, 4, 0, 4, 32'h100, 32'h103, 32'h44, 1'b0, 12'h000);
    vt[1] = mk(2'b01, 12'hFFE, 13'd4, 8'hA5, 32'h0, 16'hFFFF, 0,
               5, 16'h000F, 16'h0000, 4, 0, 0, 32'hFFE, 32'h001, 32'hA5, 1'b0, 12'h000);
    vt[2] = mk(2'b00, 12'h200, 13'd3, 8'h00, 32'h00302010, 16'hFFFF, 0,
               4, 16'h0007, 16'h0000, 3, 0, 3, 32'h200, 32'h202, 32'h30, 1'b0, 12'h000);
    vt[3] = mk(2'b10, 12'h200, 13'd3, 8'h00, 32'h00312110, 16'hFFFF, 0,
               6, 16'h0000, 16'h0015, 0, 3, 3, 32'h200, 32'h202, NONE, 1'b1, 12'h201);
    vt[4] = mk(2'b10, 12'h100, 13'd4, 8'h00, 32'h44332211, 16'hFFFF, 0,
               8, 16'h0000, 16'h0055, 0, 4, 4, 32'h100, 32'h103, NONE, 1'b0, 12'h000);
    vt[5] = mk(2'b00, 12'h300, 13'd3, 8'h00, 32'h00CCBBAA, 16'hFFF9, 1,
               6, 16'h0019, 16'h0000, 3, 0, 5, 32'h300, 32'h302, 32'hCC, 1'b0, 12'h000);
    vt[6] = mk(2'b00, 12'h050, 13'd0, 8'h00, 32'h0, 16'hFFFF, 0,
               0, 16'h0000, 16'h0000, 0, 0, 0, NONE, NONE, NONE, 1'b0, 12'h000);
    vt[7] = mk(2'b11, 12'h060, 13'd5, 8'h00, 32'h0, 16'hFFFF, 0,
               0, 16'h0000, 16'h0000, 0, 0, 0, NONE, NONE, NONE, 1'b0, 12'h000);
    vt[8] = mk(2'b01, 12'h000, 13'h1FFF, 8'h5A, 32'h0, 16'hFFFF, 0,
               4097, 16'hFFFF, 16'h0000, 4096, 0, 0, 32'h000, 32'hFFF, 32'h5A, 1'b0, 12'h000);

    rst = 1'b1;
    bus.i_START = 1'b0; bus.i_MODE = 2'b00; bus.i_BASE = '0; bus.i_LEN = '0;
    bus.i_FILL = '0; bus.i_SDATA = '0; bus.i_SVALID = 1'b0;
    #1;
    chk("rst_wr_n", 32'(bus.o_RAM_WR_n), 32'd1);
    chk("rst_rd_n", 32'(bus.o_RAM_RD_n), 32'd1);
    chk("rst_sready", 32'(bus.o_SREADY), 32'd0);
    chk("rst_busy", 32'(bus.o_BUSY), 32'd0);
    chk("rst_done", 32'(bus.o_DONE), 32'd0);
    chk("rst_err", 32'(bus.o_ERR), 32'd0);
    chk("rst_eaddr", 32'(bus.o_ERR_ADDR), 32'd0);
    chk("rst_addr", 32'(bus.o_RAM_ADDR), 32'd0);
    chk("rst_din", 32'(bus.o_RAM_DIN), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #2; end

    for (int i = 0; i < 9; i++) do_vec(vt[i], $sformatf("v%0d", i));

    // START arriving while DONE is high must be dropped.
    w0 = wr_cnt; d0 = done_cnt;
    bus.i_START = 1'b1; bus.i_MODE = 2'b00; bus.i_BASE = 12'h070; bus.i_LEN = 13'd0;
    @(posedge clk); #2;
    chk("s1_done_hi", 32'(bus.o_DONE), 32'd1);
    bus.i_MODE = 2'b01; bus.i_BASE = 12'h700; bus.i_LEN = 13'd2; bus.i_FILL = 8'h77;
    @(posedge clk); #2;
    bus.i_START = 1'b0;
    repeat (4) begin @(posedge clk); #2; end
    chk("s1_no_writes", 32'(wr_cnt - w0), 32'd0);
    chk("s1_busy", 32'(bus.o_BUSY), 32'd0);
    chk("s1_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Reset between edges in the middle of a long FILL.
    w0 = wr_cnt; d0 = done_cnt;
    bus.i_START = 1'b1; bus.i_MODE = 2'b01; bus.i_BASE = 12'h600; bus.i_LEN = 13'd100;
    bus.i_FILL = 8'h3C;
    @(posedge clk); #2;
    bus.i_START = 1'b0;
    repeat (10) begin @(posedge clk); #2; end
    chk("s3_pre_writes", 32'(wr_cnt - w0), 32'd9);
    chk("s3_pre_busy", 32'(bus.o_BUSY), 32'd1);
    rst = 1'b1;
    #1;
    chk("s3_wr_n", 32'(bus.o_RAM_WR_n), 32'd1);
    chk("s3_busy", 32'(bus.o_BUSY), 32'd0);
    chk("s3_done", 32'(bus.o_DONE), 32'd0);
    chk("s3_addr", 32'(bus.o_RAM_ADDR), 32'd0);
    chk("s3_din", 32'(bus.o_RAM_DIN), 32'd0);
    repeat (3) begin @(posedge clk); #2; end
    chk("s3_writes_held", 32'(wr_cnt - w0), 32'd9);
    chk("s3_no_done", 32'(done_cnt - d0), 32'd0);
    rst = 1'b0;
    @(posedge clk); #2;
    chk("s3_post_busy", 32'(bus.o_BUSY), 32'd0);
    chk("s3_post_writes", 32'(wr_cnt - w0), 32'd9);
    v0 = mk(2'b00, 12'h080, 13'd0, 8'h00, 32'h0, 16'hFFFF, 0,
            0, 16'h0000, 16'h0000, 0, 0, 0, NONE, NONE, NONE, 1'b0, 12'h000);
    do_vec(v0, "s3_len0");

    chk("strobe_overlap", 32'(overlap), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
